// File: rtl/thermostat_ctrl.sv
// rtl/thermostat_ctrl.sv - multi-zone heat/cool thermostat FSM with minimum run and fan overrun
module thermostat_ctrl #(
    parameter int NZONES   = 4,
    parameter int MIN_RUN  = 8,
    parameter int FAN_HOLD = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              mode,
    input  logic [NZONES-1:0] too_cold,
    input  logic [NZONES-1:0] too_hot,
    input  logic              fan_on,
    output logic              heater,
    output logic              aircon,
    output logic              fan,
    output logic [NZONES-1:0] damper,
    output logic [1:0]        state
);

    localparam int MAXV = (MIN_RUN > FAN_HOLD) ? MIN_RUN : FAN_HOLD;
    localparam int CW   = (MAXV > 1) ? $clog2(MAXV) : 1;
    localparam logic [CW-1:0] RUN_LOAD  = CW'(MIN_RUN - 1);
    localparam logic [CW-1:0] HOLD_LOAD = CW'(FAN_HOLD - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        HEAT    = 2'd1,
        COOL    = 2'd2,
        FANHOLD = 2'd3
    } state_t;

    state_t        cur;
    logic [CW-1:0] cnt;
    logic          demand_heat;
    logic          demand_cool;

    assign demand_heat = mode & (|too_cold);
    assign demand_cool = ~mode & (|too_hot);

    // heater/aircon are registered alongside the state so they change on the same edge
    always_ff @(posedge clk) begin
        if (reset) begin
            cur    <= IDLE;
            cnt    <= '0;
            heater <= 1'b0;
            aircon <= 1'b0;
        end else begin
            case (cur)
                IDLE: begin
                    if (demand_heat) begin
                        cur    <= HEAT;
                        cnt    <= RUN_LOAD;
                        heater <= 1'b1;
                    end else if (demand_cool) begin
                        cur    <= COOL;
                        cnt    <= RUN_LOAD;
                        aircon <= 1'b1;
                    end
                end
                HEAT: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else if (!demand_heat) begin
                        cur    <= FANHOLD;
                        cnt    <= HOLD_LOAD;
                        heater <= 1'b0;
                    end
                end
                COOL: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else if (!demand_cool) begin
                        cur    <= FANHOLD;
                        cnt    <= HOLD_LOAD;
                        aircon <= 1'b0;
                    end
                end
                FANHOLD: begin
                    if (demand_heat) begin
                        cur    <= HEAT;
                        cnt    <= RUN_LOAD;
                        heater <= 1'b1;
                    end else if (demand_cool) begin
                        cur    <= COOL;
                        cnt    <= RUN_LOAD;
                        aircon <= 1'b1;
                    end else if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else begin
                        cur <= IDLE;
                    end
                end
                default: begin
                    cur    <= IDLE;
                    cnt    <= '0;
                    heater <= 1'b0;
                    aircon <= 1'b0;
                end
            endcase
        end
    end

    assign state = cur;
    assign fan   = (cur != IDLE) | fan_on;

    always_comb begin
        damper = '0;
        case (cur)
            HEAT:    damper = too_cold;
            COOL:    damper = too_hot;
            FANHOLD: damper = '1;
            default: damper = '0;
        endcase
    end

endmodule

// File: tb/tb_thermostat_ctrl.sv
// tb/tb_thermostat_ctrl.sv - self-checking bench for thermostat_ctrl
module tb_thermostat_ctrl;

    localparam int NZ = 4;
    localparam int MR = 8;
    localparam int FH = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          mode;
    logic [NZ-1:0] too_cold;
    logic [NZ-1:0] too_hot;
    logic          fan_on;
    logic          heater;
    logic          aircon;
    logic          fan;
    logic [NZ-1:0] damper;
    logic [1:0]    state;

    int checks = 0;
    int errors = 0;

    thermostat_ctrl #(.NZONES(NZ), .MIN_RUN(MR), .FAN_HOLD(FH)) dut (
        .clk(clk), .reset(reset), .mode(mode), .too_cold(too_cold), .too_hot(too_hot),
        .fan_on(fan_on), .heater(heater), .aircon(aircon), .fan(fan), .damper(damper),
        .state(state)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          rst;
        logic          m;
        logic [NZ-1:0] c;
        logic [NZ-1:0] h;
        logic          f;
        logic [1:0]    st;
        logic          ht;
        logic          ac;
        logic          fn;
        logic [NZ-1:0] d;
    } vec_t;

    vec_t tbl[12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic r, input logic m, input logic [NZ-1:0] c,
                         input logic [NZ-1:0] h, input logic f);
        reset = r; mode = m; too_cold = c; too_hot = h; fan_on = f;
        @(posedge clk);
        #1;
    endtask

    task automatic check_all(input string tag, input int st, input logic f_on,
                             input logic [NZ-1:0] c, input logic [NZ-1:0] h);
        logic [NZ-1:0] d;
        d = (st == 1) ? c : (st == 2) ? h : (st == 3) ? {NZ{1'b1}} : '0;
        chk({tag, ".state"},  32'(state),  32'(st));
        chk({tag, ".heater"}, 32'(heater), 32'(st == 1));
        chk({tag, ".aircon"}, 32'(aircon), 32'(st == 2));
        chk({tag, ".fan"},    32'(fan),    32'((st != 0) || f_on));
        chk({tag, ".damper"}, 32'(damper), 32'(d));
        chk({tag, ".overlap"}, 32'(heater & aircon), 32'(0));
    endtask

    // Reference: state plus how many cycles have been spent in it
    int m_st;
    int m_age;

    task automatic model_step(input logic r, input logic m, input logic [NZ-1:0] c,
                              input logic [NZ-1:0] h);
        bit dh, dc;
        dh = m && (c != 0);
        dc = !m && (h != 0);
        if (r) begin
            m_st = 0; m_age = 0;
        end else if (m_st == 0 || m_st == 3) begin
            if (dh)                          begin m_st = 1; m_age = 1; end
            else if (dc)                     begin m_st = 2; m_age = 1; end
            else if (m_st == 3 && m_age < FH) m_age++;
            else                             begin m_st = 0; m_age = 0; end
        end else begin
            if (m_age < MR || (m_st == 1 ? dh : dc)) m_age++;
            else begin m_st = 3; m_age = 1; end
        end
    endtask

    initial begin
        reset = 1'b1; mode = 1'b0; too_cold = '0; too_hot = '0; fan_on = 1'b0;

        tbl[0]  = '{1'b1, 1'b1, 4'b0000, 4'b0000, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 4'b0000};
        tbl[1]  = '{1'b1, 1'b1, 4'b0000, 4'b0000, 1'b1, 2'd0, 1'b0, 1'b0, 1'b1, 4'b0000};
        tbl[2]  = '{1'b0, 1'b1, 4'b0001, 4'b0000, 1'b0, 2'd1, 1'b1, 1'b0, 1'b1, 4'b0001};
        tbl[3]  = '{1'b0, 1'b1, 4'b0001, 4'b0000, 1'b0, 2'd1, 1'b1, 1'b0, 1'b1, 4'b0001};
        tbl[4]  = '{1'b0, 1'b1, 4'b0011, 4'b0000, 1'b0, 2'd1, 1'b1, 1'b0, 1'b1, 4'b0011};
        tbl[5]  = '{1'b1, 1'b1, 4'b0011, 4'b0000, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 4'b0000};
        tbl[6]  = '{1'b0, 1'b0, 4'b0000, 4'b0100, 1'b0, 2'd2, 1'b0, 1'b1, 1'b1, 4'b0100};
        tbl[7]  = '{1'b0, 1'b0, 4'b0000, 4'b0110, 1'b0, 2'd2, 1'b0, 1'b1, 1'b1, 4'b0110};
        tbl[8]  = '{1'b1, 1'b0, 4'b0000, 4'b0110, 1'b1, 2'd0, 1'b0, 1'b0, 1'b1, 4'b0000};
        tbl[9]  = '{1'b0, 1'b1, 4'b0000, 4'b0110, 1'b1, 2'd0, 1'b0, 1'b0, 1'b1, 4'b0000};
        tbl[10] = '{1'b0, 1'b0, 4'b1111, 4'b0000, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 4'b0000};
        tbl[11] = '{1'b0, 1'b1, 4'b1000, 4'b0000, 1'b0, 2'd1, 1'b1, 1'b0, 1'b1, 4'b1000};

        for (int i = 0; i < 12; i++) begin
            drive(tbl[i].rst, tbl[i].m, tbl[i].c, tbl[i].h, tbl[i].f);
            chk($sformatf("tbl%0d.state", i),  32'(state),  32'(tbl[i].st));
            chk($sformatf("tbl%0d.heater", i), 32'(heater), 32'(tbl[i].ht));
            chk($sformatf("tbl%0d.aircon", i), 32'(aircon), 32'(tbl[i].ac));
            chk($sformatf("tbl%0d.fan", i),    32'(fan),    32'(tbl[i].fn));
            chk($sformatf("tbl%0d.damper", i), 32'(damper), 32'(tbl[i].d));
        end

        // Short heat demand: exact minimum run then exact fan overrun
        drive(1'b1, 1'b1, '0, '0, 1'b0);
        for (int i = 1; i <= 13; i++) begin
            logic [NZ-1:0] c;
            c = (i <= 2) ? 4'b0100 : 4'b0000;
            drive(1'b0, 1'b1, c, '0, 1'b0);
            check_all($sformatf("run%0d", i), (i <= MR) ? 1 : (i <= MR + FH) ? 3 : 0, 1'b0, c, '0);
        end

        // Season change mid-heat: heater holds, one FANHOLD cycle, then cool
        drive(1'b1, 1'b1, '0, '0, 1'b0);
        for (int i = 1; i <= 11; i++) begin
            if (i <= 3) begin
                drive(1'b0, 1'b1, 4'b0001, '0, 1'b0);
                check_all($sformatf("chg%0d", i), 1, 1'b0, 4'b0001, '0);
            end else begin
                drive(1'b0, 1'b0, '0, 4'b0010, 1'b0);
                check_all($sformatf("chg%0d", i), (i <= MR) ? 1 : (i == MR + 1) ? 3 : 2, 1'b0, '0, 4'b0010);
            end
        end

        // Demand returns during fan overrun: minimum run restarts in full
        drive(1'b1, 1'b1, '0, '0, 1'b0);
        for (int i = 1; i <= 19; i++) begin
            logic [NZ-1:0] c;
            c = (i == 1) ? 4'b0001 : (i == 11) ? 4'b1000 : 4'b0000;
            drive(1'b0, 1'b1, c, '0, 1'b0);
            check_all($sformatf("rel%0d", i),
                      (i <= MR) ? 1 : (i <= 10) ? 3 : (i <= 18) ? 1 : 3, 1'b0, c, '0);
        end

        // Reset mid-cool with the user fan request held
        drive(1'b1, 1'b0, '0, '0, 1'b1);
        drive(1'b0, 1'b0, '0, 4'b0001, 1'b1);
        drive(1'b0, 1'b0, '0, 4'b0001, 1'b1);
        chk("midcool.state", 32'(state), 32'(2));
        drive(1'b1, 1'b0, '0, 4'b0001, 1'b1);
        check_all("rstcool", 0, 1'b1, '0, 4'b0001);

        // Random run against the reference model
        m_st = 0; m_age = 0;
        begin
            logic          r, m, f;
            logic [NZ-1:0] c, h;
            m = 1'b1;
            for (int i = 0; i < 200; i++) begin
                r = (i == 0) || ($urandom_range(0, 31) == 0);
                if ($urandom_range(0, 7) == 0) m = ~m;
                c = ($urandom_range(0, 1) == 0) ? '0 : NZ'($urandom);
                h = ($urandom_range(0, 1) == 0) ? '0 : NZ'($urandom);
                f = NZ'($urandom) == '0;
                model_step(r, m, c, h);
                drive(r, m, c, h, f);
                check_all($sformatf("rnd%0d", i), m_st, f, c, h);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
